v_upd_issue: RTL

//  Issue stage directly upstream of the list-update pipeline. Accepts update commands on a

---
 rtl/v_pkg.sv | 30 +++
 rtl/v_upd_fifo.sv | 56 +++++
 rtl/v_upd_issue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/v_pkg.sv
// Shared types for the list-update path: command fields, the update bundle
// carried from the issue stage into the pipeline, and the issue FIFO depth.
package v_pkg;

    localparam int ID_W   = 4;
    localparam int CMD_W  = 2;
    localparam int KEY_W  = 8;
    localparam int SIZE_W = 8;

    typedef logic [ID_W-1:0]   id_t;
    typedef logic [CMD_W-1:0]  cmd_t;
    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [SIZE_W-1:0] size_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

    localparam int UPD_W       = $bits(upd_t);
    localparam int UPD_ISSUE_N = 4;

    // True when an occupied slot carries the given producer id.
    function automatic logic id_hit(input logic vld, input id_t slot_id, input id_t id);
        return vld && (slot_id == id);
    endfunction

endpackage

// File: rtl/v_upd_fifo.sv
// In-order FIFO of update commands. The caller guarantees push only when not
// full and pop only when not empty; pointers wrap naturally since N is a
// power of two. Head data is a direct read of the read-pointer slot.
module v_upd_fifo
    import v_pkg::*;
#(
    parameter int  N = UPD_ISSUE_N,
    parameter type T = upd_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(N):0]     occ,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(N);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(N);

    T              mem [N];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; contents need no reset because occ gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves occ unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (occ == FULL_OCC);
    assign empty = (occ == '0);

endmodule

// File: rtl/v_upd_issue.sv
// Issue stage ahead of the list-update pipeline. Commands are buffered in an
// in-order FIFO; the head is issued onto a registered one-cycle update bus
// unless its producer already has an update in flight (issue register or
// pipeline S1..S4), which keeps at most one update per producer in flight.
//
// Input handshake: a command transfers on a rising clk edge where
// i_in_vld and o_in_rdy are both high. o_in_rdy depends only on rst and the
// registered occupancy, never on i_in_vld or on a same-cycle pop, so a full
// FIFO cannot accept even in the cycle it issues. The update bus has no
// backpressure: o_upd_vld_r high for one cycle is one update.
module v_upd_issue
    import v_pkg::*;
#(
    parameter int N       = UPD_ISSUE_N,
    parameter int STALL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_vld,
    output logic                  o_in_rdy,
    input  id_t                   i_in_prod_id,
    input  cmd_t                  i_in_cmd,
    input  key_t                  i_in_key,
    input  size_t                 i_in_size,
    input  logic                  i_s1_upd_vld_r,
    input  id_t                   i_s1_upd_prod_id_r,
    input  logic                  i_s2_upd_vld_r,
    input  id_t                   i_s2_upd_prod_id_r,
    input  logic                  i_s3_upd_vld_r,
    input  id_t                   i_s3_upd_prod_id_r,
    input  logic                  i_s4_upd_vld_r,
    input  id_t                   i_s4_upd_prod_id_r,
    output logic                  o_upd_vld_r,
    output id_t                   o_upd_prod_id_r,
    output cmd_t                  o_upd_cmd_r,
    output key_t                  o_upd_key_r,
    output size_t                 o_upd_size_r,
    output logic [$clog2(N):0]    o_occ_r,
    output logic                  o_busy,
    input  logic                  i_stall_clr,
    output logic [STALL_W-1:0]    o_stall_cnt_r
);

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               hz;
    upd_t               in_upd;
    upd_t               head_upd;
    logic [$clog2(N):0] occ;

    assign in_upd = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};

    assign o_in_rdy = !rst && !full;
    assign push     = i_in_vld && o_in_rdy;

    v_upd_fifo #(
        .N (N),
        .T (upd_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_upd),
        .pop       (pop),
        .head      (head_upd),
        .occ       (occ),
        .full      (full),
        .empty     (empty)
    );

    // Head collides with any in-flight update: issue register or pipeline S1..S4.
    always_comb begin
        hz = id_hit(o_upd_vld_r,    o_upd_prod_id_r,    head_upd.prod_id)
           | id_hit(i_s1_upd_vld_r, i_s1_upd_prod_id_r, head_upd.prod_id)
           | id_hit(i_s2_upd_vld_r, i_s2_upd_prod_id_r, head_upd.prod_id)
           | id_hit(i_s3_upd_vld_r, i_s3_upd_prod_id_r, head_upd.prod_id)
           | id_hit(i_s4_upd_vld_r, i_s4_upd_prod_id_r, head_upd.prod_id);
    end

    assign pop = !empty && !hz;

    // Issue register: one-cycle pulse on pop; payload holds between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_cmd_r     <= '0;
            o_upd_key_r     <= '0;
            o_upd_size_r    <= '0;
        end else begin
            o_upd_vld_r <= pop;
            if (pop) begin
                o_upd_prod_id_r <= head_upd.prod_id;
                o_upd_cmd_r     <= head_upd.cmd;
                o_upd_key_r     <= head_upd.key;
                o_upd_size_r    <= head_upd.size;
            end
        end
    end

    // Saturating count of cycles the head was held back by a hazard; clear wins.
    always_ff @(posedge clk) begin
        if (rst || i_stall_clr) begin
            o_stall_cnt_r <= '0;
        end else if (!empty && hz && (o_stall_cnt_r != '1)) begin
            o_stall_cnt_r <= o_stall_cnt_r + 1'b1;
        end
    end

    // Structural invariants of the push/pop control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
            assert (!(pop && empty));
            assert (!(pop && hz));
        end
    end

    assign o_occ_r = occ;
    assign o_busy  = (occ != '0) || o_upd_vld_r;

endmodule
